// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a single shared ALU. One operation is in flight
// at a time; its result is held until the owning requester takes it.
module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [3:0]  req0_op,
   input  logic [31:0] req0_src1,
   input  logic [31:0] req0_src2,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [3:0]  req1_op,
   input  logic [31:0] req1_src1,
   input  logic [31:0] req1_src2,

   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,

   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,

   output logic        busy
);

   localparam int unsigned DW  = 32;
   localparam int unsigned OPW = 4;
   localparam int unsigned SHW = 5;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            last_grant_q, last_grant_d;
   logic [DW-1:0]   result_q, result_d;

   logic            grant;
   logic [OPW-1:0]  sel_op;
   logic [DW-1:0]   sel_src1;
   logic [DW-1:0]   sel_src2;
   logic [DW-1:0]   alu_out;

   function automatic logic [DW-1:0] alu(input logic [OPW-1:0] op,
                                         input logic [DW-1:0]  a,
                                         input logic [DW-1:0]  b);
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      case (op)
         4'd0:    alu = a + b;
         4'd1:    alu = DW'($signed(a) < $signed(b));
         4'd2:    alu = DW'(a < b);
         4'd3:    alu = a ^ b;
         4'd4:    alu = a | b;
         4'd5:    alu = a & b;
         4'd6:    alu = a << sh;
         4'd7:    alu = a >> sh;
         4'd8:    alu = DW'($signed(a) >>> sh);
         4'd9:    alu = a - b;
         default: alu = '0;
      endcase
   endfunction

   // Contention goes to the port that did not win last (round-robin) or to port 0.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = RR_EN ? ~last_grant_q : 1'b0;
      end
   end

   assign sel_op   = grant ? req1_op   : req0_op;
   assign sel_src1 = grant ? req1_src1 : req0_src1;
   assign sel_src2 = grant ? req1_src2 : req0_src2;
   assign alu_out  = alu(sel_op, sel_src1, sel_src2);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         result_q     <= result_d;
      end
   end

   // Next state and request-side handshake
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      result_d     = result_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rst && (req0_valid || req1_valid)) begin
               req0_ready   = ~grant;
               req1_ready   = grant;
               state_d      = BUSY;
               owner_d      = grant;
               last_grant_d = grant;
               result_d     = alu_out;
            end
         end
         BUSY: begin
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy        = (state_q == BUSY);
   assign rsp0_valid  = busy && !owner_q;
   assign rsp1_valid  = busy &&  owner_q;
   assign rsp0_result = owner_q ? '0 : result_q;
   assign rsp1_result = owner_q ? result_q : '0;

endmodule
